// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// A prescaler divides clk into digit slots. Each slot begins with GUARD
// blank cycles so the previous digit's pattern cannot ghost onto the next
// anode. New data is staged on load and only reaches the display register
// at a frame boundary, so one scan never mixes old and new digits.
// All pin outputs are registered.

module seven_segment_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 16,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              segment,
   output logic                    dp,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
   localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

   // One complete set of digit data: nibbles, decimal points and enables.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] nibbles;
      logic [NUM_DIGITS-1:0]   dots;
      logic [NUM_DIGITS-1:0]   enables;
   } frame_t;

   // Out of reset every digit is enabled. With all-zero nibbles this
   // shows a single '0' on digit 0, which proves the scan is alive.
   localparam frame_t RESET_FRAME = {{(4*NUM_DIGITS){1'b0}},
                                     {NUM_DIGITS{1'b0}},
                                     {NUM_DIGITS{1'b1}}};

   logic [PW-1:0]         presc;
   logic [IW-1:0]         index;
   logic                  tick;
   frame_t                staging;
   frame_t                display;
   frame_t                incoming;

   logic [NUM_DIGITS-1:0] suppress;
   logic                  all_zero;
   logic [3:0]            cur_nibble;
   logic                  cur_en;
   logic                  cur_dot;
   logic                  cur_sup;
   logic [6:0]            seg_decoded;
   logic [NUM_DIGITS-1:0] anode_sel;
   logic                  in_guard;

   assign tick       = (presc == PRESC_LAST);
   assign frame_done = tick && (index == INDEX_LAST);
   assign in_guard   = (presc < GUARD_END);
   assign incoming   = {value, dp_in, digit_en};

   // Slot prescaler: counts 0..REFRESH_DIV-1, wraps on the tick.
   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values; blocking here would create order races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Digit index: steps once per slot, wrapping after the last digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         index <= '0;
      end else if (tick) begin
         if (index == INDEX_LAST) begin
            index <= '0;
         end else begin
            index <= index + 1'b1;
         end
      end
   end

   // Staging and display registers: load goes to staging, and staging moves
   // to display only on the frame boundary. A load on the boundary itself
   // bypasses staging.
   // NOTE: these data registers are reset on purpose, so a reset aborts any
   // captured load and the first frame shows known content.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         staging <= RESET_FRAME;
         display <= RESET_FRAME;
         pending <= 1'b0;
      end else if (load && frame_done) begin
         staging <= incoming;
         display <= incoming;
         pending <= 1'b0;
      end else if (load) begin
         staging <= incoming;
         pending <= 1'b1;
      end else if (frame_done) begin
         if (pending) begin
            display <= staging;
         end
         pending <= 1'b0;
      end
   end

   // Leading-zero map: a digit above 0 is blanked when it and every higher
   // digit hold a zero nibble.
   // NOTE: every combinational output gets a default first, so no path
   // through the block can leave a variable unassigned and infer a latch.
   always_comb begin
      all_zero = 1'b1;
      suppress = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & (display.nibbles[4*i +: 4] == 4'h0);
         if (i > 0) begin
            suppress[i] = all_zero & (LZ_SUPPRESS != 0);
         end
      end
   end

   // Select the data and the anode pattern of the digit currently being scanned.
   always_comb begin
      cur_nibble = 4'h0;
      cur_en     = 1'b0;
      cur_dot    = 1'b0;
      cur_sup    = 1'b0;
      anode_sel  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (index == IW'(i)) begin
            cur_nibble   = display.nibbles[4*i +: 4];
            cur_en       = display.enables[i];
            cur_dot      = display.dots[i];
            cur_sup      = suppress[i];
            anode_sel[i] = 1'b0;
         end
      end
   end

   // Hex to active-low segment decode, bit6 = a through bit0 = g.
   always_comb begin
      seg_decoded = 7'b1111111;
      case (cur_nibble)
         4'h0: seg_decoded = 7'b0000001;
         4'h1: seg_decoded = 7'b1001111;
         4'h2: seg_decoded = 7'b0010010;
         4'h3: seg_decoded = 7'b0000110;
         4'h4: seg_decoded = 7'b1001100;
         4'h5: seg_decoded = 7'b0100100;
         4'h6: seg_decoded = 7'b0100000;
         4'h7: seg_decoded = 7'b0001111;
         4'h8: seg_decoded = 7'b0000000;
         4'h9: seg_decoded = 7'b0000100;
         4'hA: seg_decoded = 7'b0001000;
         4'hB: seg_decoded = 7'b1100000;
         4'hC: seg_decoded = 7'b0110001;
         4'hD: seg_decoded = 7'b1000010;
         4'hE: seg_decoded = 7'b0110000;
         4'hF: seg_decoded = 7'b0111000;
         default: seg_decoded = 7'b1111111;
      endcase
   end

   // Pin registers: the anode is blank during the guard window. Disabled
   // digits are fully blank. Suppressed digits blank their segments but keep
   // their decimal point.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         anode   <= '1;
         segment <= 7'b1111111;
         dp      <= 1'b1;
      end else begin
         anode   <= in_guard ? '1 : anode_sel;
         segment <= (cur_en && !cur_sup) ? seg_decoded : 7'b1111111;
         dp      <= cur_en ? ~cur_dot : 1'b1;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
// Directed test of the scanner with NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
// A cycle-level reference model derived from elapsed time predicts every
// pin. Hand-computed literal checks pin the model to known values.

module tb_seven_segment_scanner;

   localparam int N  = 4;
   localparam int RD = 8;
   localparam int G  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   value;
   logic [3:0]    dp_in;
   logic [3:0]    digit_en;
   logic          load;
   logic [3:0]    anode;
   logic [6:0]    segment;
   logic          dp;
   logic          pending;
   logic          frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   seven_segment_scanner #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(RD),
      .GUARD      (G),
      .LZ_SUPPRESS(1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .value     (value),
      .dp_in     (dp_in),
      .digit_en  (digit_en),
      .load      (load),
      .anode     (anode),
      .segment   (segment),
      .dp        (dp),
      .pending   (pending),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] seg_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   int          t;          // cycles since reset release
   bit          valid = 0;
   logic [15:0] m_val, s_val;
   logic [3:0]  m_dp, m_en, s_dp, s_en;
   bit          m_pend;
   int          mp, midx;
   bit          mfd;
   logic [3:0]  e_anode;
   logic [6:0]  e_seg;
   logic        e_dp;
   bit          e_fd;

   always @(posedge clk) begin
      if (!rst_n) begin
         t = 0;
         m_val = 16'h0; m_dp = 4'h0; m_en = 4'hF;
         s_val = 16'h0; s_dp = 4'h0; s_en = 4'hF;
         m_pend = 0;
         e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         valid = 1;
      end else begin
         mp   = t % RD;
         midx = (t / RD) % N;
         mfd  = (mp == RD - 1) && (midx == N - 1);
         e_anode = (mp < G) ? 4'hF : ~(4'b0001 << midx);
         if (!m_en[midx]) begin
            e_seg = 7'h7F; e_dp = 1'b1;
         end else if (midx > 0 && (m_val >> (4 * midx)) == 16'h0) begin
            e_seg = 7'h7F; e_dp = ~m_dp[midx];
         end else begin
            e_seg = seg_tbl[(m_val >> (4 * midx)) & 16'hF];
            e_dp  = ~m_dp[midx];
         end
         if (load && mfd) begin
            s_val = value; s_dp = dp_in; s_en = digit_en;
            m_val = value; m_dp = dp_in; m_en = digit_en;
            m_pend = 0;
         end else if (load) begin
            s_val = value; s_dp = dp_in; s_en = digit_en;
            m_pend = 1;
         end else if (mfd) begin
            if (m_pend) begin
               m_val = s_val; m_dp = s_dp; m_en = s_en;
            end
            m_pend = 0;
         end
         t++;
      end
      e_fd = (t % RD == RD - 1) && ((t / RD) % N == N - 1);
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (valid) begin
         check("anode", anode, e_anode);
         check("segment", segment, e_seg);
         check("dp", dp, e_dp);
         check("pending", pending, m_pend);
         check("frame_done", frame_done, e_fd);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic load_word(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      @(negedge clk);
      if (frame_done) @(negedge clk);
      value = v; dp_in = d; digit_en = e; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_fd();
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (frame_done) seen = 1;
      end
      if (!seen) check("frame_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic capture(output logic [3:0][6:0] segs, output logic [3:0] dps);
      segs = '1;
      dps  = '0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (anode == ~(4'b0001 << i)) begin
               segs[i] = segment;
               dps[i]  = dp;
            end
         end
      end
   endtask

   logic [3:0][6:0] segs;
   logic [3:0]      dps;
   int              first_lit;
   logic [6:0]      first_seg;
   int              cnt [5];
   int              fd_cnt;

   initial begin
      rst_n = 1'b0; value = 16'h0; dp_in = 4'h0; digit_en = 4'hF; load = 1'b0;
      @(negedge clk);
      value = 16'h9999; load = 1'b1;        // load during reset must be ignored
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      check("rst_anode", anode, 4'b1111);
      check("rst_segment", segment, 7'b1111111);
      check("rst_dp", dp, 1'b1);
      check("rst_pending", pending, 1'b0);
      value = 16'h0;
      rst_n = 1'b1;

      first_lit = -1;
      first_seg = 7'h7F;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (first_lit < 0 && anode == 4'b1110) begin
            first_lit = k;
            first_seg = segment;
         end
      end
      check("first_lit_cycle", first_lit, 3);
      check("first_lit_segment", first_seg, 7'b0000001);

      foreach (cnt[i]) cnt[i] = 0;
      fd_cnt = 0;
      repeat (64) begin
         @(negedge clk);
         case (anode)
            4'b1110: cnt[0]++;
            4'b1101: cnt[1]++;
            4'b1011: cnt[2]++;
            4'b0111: cnt[3]++;
            4'b1111: cnt[4]++;
            default: ;
         endcase
         if (frame_done) fd_cnt++;
      end
      check("scan_d0", cnt[0], 12);
      check("scan_d1", cnt[1], 12);
      check("scan_d2", cnt[2], 12);
      check("scan_d3", cnt[3], 12);
      check("scan_blank", cnt[4], 16);
      check("scan_frame_done", fd_cnt, 2);

      // Frame-safe load.
      load_word(16'h1234, 4'h0, 4'hF);
      check("load_pending", pending, 1'b1);
      wait_fd();
      check("pending_at_fd", pending, 1'b1);
      @(negedge clk);
      check("pending_cleared", pending, 1'b0);
      capture(segs, dps);
      check("f1234_d0", segs[0], 7'b1001100);
      check("f1234_d1", segs[1], 7'b0000110);
      check("f1234_d2", segs[2], 7'b0010010);
      check("f1234_d3", segs[3], 7'b1001111);

      // Leading-zero suppression.
      load_word(16'h0050, 4'h0, 4'hF);
      wait_fd();
      @(negedge clk);
      capture(segs, dps);
      check("lz_d0", segs[0], 7'b0000001);
      check("lz_d1", segs[1], 7'b0100100);
      check("lz_d2", segs[2], 7'b1111111);
      check("lz_d3", segs[3], 7'b1111111);

      // Load coinciding with frame_done.
      wait_fd();
      value = 16'hAAAA; dp_in = 4'h0; digit_en = 4'hF; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("coinc_pending", pending, 1'b0);
      capture(segs, dps);
      for (int i = 0; i < 4; i++) check("coinc_seg", segs[i], 7'b0001000);

      // Overwritten staging.
      load_word(16'h1111, 4'h0, 4'hF);
      repeat (3) @(negedge clk);
      load_word(16'hFFFF, 4'h0, 4'hF);
      check("ovw_pending", pending, 1'b1);
      wait_fd();
      @(negedge clk);
      capture(segs, dps);
      for (int i = 0; i < 4; i++) check("ovw_seg", segs[i], 7'b0111000);

      // Digit masking and decimal points.
      load_word(16'h1234, 4'b0011, 4'b1010);
      wait_fd();
      @(negedge clk);
      capture(segs, dps);
      check("mask_d0_seg", segs[0], 7'b1111111);
      check("mask_d0_dp", dps[0], 1'b1);
      check("mask_d1_seg", segs[1], 7'b0000110);
      check("mask_d1_dp", dps[1], 1'b0);
      check("mask_d2_seg", segs[2], 7'b1111111);
      check("mask_d2_dp", dps[2], 1'b1);
      check("mask_d3_seg", segs[3], 7'b1001111);
      check("mask_d3_dp", dps[3], 1'b1);

      // Reset while a load is pending aborts it.
      load_word(16'h5555, 4'h0, 4'hF);
      check("abort_pending_set", pending, 1'b1);
      rst_n = 1'b0; value = 16'h7777; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("abort_pending_clr", pending, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_anode", anode, 4'b1110);
      check("abort_segment", segment, 7'b0000001);
      repeat (40) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
